// File: rtl/ex_control_mc_pkg.sv
// Shared constants and types for the EX-stage controller: function codes,
// result-mux select, FSM states and the op-class decode helper.
package ex_ctrl_pkg;

  localparam logic [5:0] FN_MADD  = 6'h00;
  localparam logic [5:0] FN_MADDU = 6'h01;
  localparam logic [5:0] FN_MUL   = 6'h02;
  localparam logic [5:0] FN_MSUB  = 6'h04;
  localparam logic [5:0] FN_MSUBU = 6'h05;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_CLZ   = 6'h20;
  localparam logic [5:0] FN_CLO   = 6'h21;

  typedef enum logic [1:0] {
    OUT_ALU = 2'b00,
    OUT_BRA = 2'b01,
    OUT_MUL = 2'b10,
    OUT_DIV = 2'b11
  } out_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACC_BUSY = 2'd1,
    GPR_BUSY = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_OTHER,
    CLS_ACC_MUL,
    CLS_ACC_DIV,
    CLS_GPR_MUL,
    CLS_ACC_MOVE,
    CLS_CNT
  } op_class_e;

  function automatic op_class_e classify(input logic alu_op, input logic mul_op,
                                         input logic [5:0] func);
    op_class_e cls;
    cls = CLS_OTHER;
    if (alu_op) begin
      case (func)
        FN_MULT, FN_MULTU:                  cls = CLS_ACC_MUL;
        FN_DIV, FN_DIVU:                    cls = CLS_ACC_DIV;
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: cls = CLS_ACC_MOVE;
        default:                            cls = CLS_OTHER;
      endcase
    end else if (mul_op) begin
      case (func)
        FN_MADD, FN_MADDU, FN_MSUB, FN_MSUBU: cls = CLS_ACC_MUL;
        FN_MUL:                               cls = CLS_GPR_MUL;
        FN_CLZ, FN_CLO:                       cls = CLS_CNT;
        default:                              cls = CLS_OTHER;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/ex_control_mc_if.sv
// ID/EX control fields in, datapath enables out; master drives decode, slave is the controller.
interface ex_control_mc_if;
  logic       Valid;
  logic       Flush;
  logic       ALUOp;
  logic       MULOp;
  logic       Jump;
  logic       Branch;
  logic       BRAtaken;
  logic       RegWriteIn;
  logic       ALUEn;
  logic       MemWrite;
  logic [5:0] Func;
  logic       ACCEn;
  logic       MULSelB;
  logic       MulStart;
  logic       DivStart;
  logic       RegWriteOut;
  logic       BRAEn;
  logic       BranchTaken;
  logic       Stall;
  logic       AccBusy;
  logic [1:0] OutSel;

  modport master (
    output Valid, Flush, ALUOp, MULOp, Jump, Branch, BRAtaken, RegWriteIn, ALUEn, MemWrite, Func,
    input  ACCEn, MULSelB, MulStart, DivStart, RegWriteOut, BRAEn, BranchTaken, Stall, AccBusy, OutSel
  );

  modport slave (
    input  Valid, Flush, ALUOp, MULOp, Jump, Branch, BRAtaken, RegWriteIn, ALUEn, MemWrite, Func,
    output ACCEn, MULSelB, MulStart, DivStart, RegWriteOut, BRAEn, BranchTaken, Stall, AccBusy, OutSel
  );
endinterface

// File: rtl/ex_control_mc_lat_counter.sv
// Loadable down-counter that saturates at zero; done_o marks the last busy cycle (count==1).
module ex_lat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/ex_control_mc.sv
// EX-stage controller: single-cycle ALU/branch decode plus MUL/DIV sequencing
// with a HI/LO interlock and a GPR-writing multiply stall.
module ex_control_mc
  import ex_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic           clk,
  input  logic           nrst,
  ex_control_mc_if.slave bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_e           state_q, state_d;
  op_class_e        op_cls;
  logic             acc_user;
  logic             interlock;
  logic             issue;
  logic             cnt_load;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_load_val;

  assign op_cls    = classify(bus.ALUOp, bus.MULOp, bus.Func);
  assign acc_user  = op_cls inside {CLS_ACC_MUL, CLS_ACC_DIV, CLS_GPR_MUL, CLS_ACC_MOVE};
  // Accumulator users wait out the in-flight op, including its completion cycle.
  assign interlock = (state_q == ACC_BUSY) && bus.Valid && acc_user;
  assign issue     = bus.Valid && !bus.Flush && !interlock && (state_q != GPR_BUSY);

  ex_lat_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .nrst       (nrst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d         = state_q;
    cnt_load        = 1'b0;
    cnt_load_val    = '0;
    bus.ACCEn       = 1'b0;
    bus.MULSelB     = 1'b0;
    bus.MulStart    = 1'b0;
    bus.DivStart    = 1'b0;
    bus.RegWriteOut = 1'b0;
    bus.BRAEn       = bus.Jump | bus.Branch;
    bus.BranchTaken = 1'b0;
    bus.Stall       = 1'b0;
    bus.AccBusy     = 1'b0;
    bus.OutSel      = OUT_ALU;

    case (state_q)
      ACC_BUSY: begin
        bus.AccBusy = 1'b1;
        bus.Stall   = interlock;
        if (cnt_done) begin
          bus.ACCEn = 1'b1;
          state_d   = IDLE;
        end
      end
      GPR_BUSY: begin
        if (bus.Flush) begin
          cnt_load = 1'b1;
          state_d  = IDLE;
        end else if (cnt_done) begin
          bus.OutSel      = OUT_MUL;
          bus.RegWriteOut = bus.RegWriteIn;
          bus.MULSelB     = 1'b1;
          state_d         = IDLE;
        end else begin
          bus.Stall = 1'b1;
        end
      end
      default: ;
    endcase

    if (issue) begin
      bus.RegWriteOut = bus.RegWriteIn;
      case (op_cls)
        CLS_ACC_MUL: begin
          bus.MulStart    = 1'b1;
          bus.MULSelB     = 1'b1;
          bus.OutSel      = OUT_MUL;
          bus.RegWriteOut = 1'b0;
          cnt_load        = 1'b1;
          cnt_load_val    = MUL_LOAD;
          if (MUL_LAT == 1) begin
            bus.ACCEn = 1'b1;
          end else begin
            bus.AccBusy = 1'b1;
            state_d     = ACC_BUSY;
          end
        end
        CLS_ACC_DIV: begin
          bus.DivStart    = 1'b1;
          bus.OutSel      = OUT_DIV;
          bus.RegWriteOut = 1'b0;
          bus.AccBusy     = 1'b1;
          cnt_load        = 1'b1;
          cnt_load_val    = DIV_LOAD;
          state_d         = ACC_BUSY;
        end
        CLS_GPR_MUL: begin
          bus.MulStart = 1'b1;
          bus.MULSelB  = 1'b1;
          bus.OutSel   = OUT_MUL;
          if (MUL_LAT > 1) begin
            bus.Stall       = 1'b1;
            bus.RegWriteOut = 1'b0;
            cnt_load        = 1'b1;
            cnt_load_val    = MUL_LOAD;
            state_d         = GPR_BUSY;
          end
        end
        CLS_ACC_MOVE: begin
          bus.ACCEn  = (bus.Func == FN_MTHI) || (bus.Func == FN_MTLO);
          bus.OutSel = OUT_MUL;
        end
        CLS_CNT: bus.OutSel = OUT_MUL;
        default: begin
          if (bus.Jump) begin
            bus.OutSel      = OUT_BRA;
            bus.BranchTaken = 1'b1;
          end else if (bus.Branch) begin
            bus.OutSel      = OUT_BRA;
            bus.BranchTaken = bus.BRAtaken;
            bus.RegWriteOut = bus.RegWriteIn & bus.BRAtaken;
          end else begin
            bus.RegWriteOut = bus.ALUEn & ~bus.MemWrite;
          end
        end
      endcase
    end

    // A reset cycle must not launch or retire anything.
    if (!nrst) begin
      bus.ACCEn    = 1'b0;
      bus.MulStart = 1'b0;
      bus.DivStart = 1'b0;
      bus.Stall    = 1'b0;
      bus.AccBusy  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_ex_control_mc.sv
// Scoreboard bench for ex_control_mc: per-cycle stimulus and expected outputs are queued, then replayed and compared.
module tb_ex_control_mc;
  import ex_ctrl_pkg::*;

  typedef struct {
    logic       rn, v, fl, alu, mul, j, br, tk, rwi, alue, mw;
    logic [5:0] fn;
  } in_t;

  typedef struct {
    string       nm;
    logic [10:0] val;
    logic [10:0] mask;
  } exp_t;

  localparam logic [10:0] M_ALL  = 11'h7FF;
  localparam logic [10:0] M_HOLD = 11'h5FC;
  localparam logic [10:0] M_NOOS = 11'h7FC;

  logic clk = 1'b0;
  logic nrst;
  in_t  stim_q[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_control_mc_if bus();

  ex_control_mc #(.MUL_LAT(3), .DIV_LAT(32)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // Packed order: ACCEn MULSelB MulStart DivStart RegWriteOut BRAEn BranchTaken Stall AccBusy OutSel[1:0]
  function automatic logic [10:0] ev(input logic acc, selb, ms, ds, rw, bra, bt, st, ab,
                                     input logic [1:0] os);
    return {acc, selb, ms, ds, rw, bra, bt, st, ab, os};
  endfunction

  function automatic logic [10:0] obs();
    return {bus.ACCEn, bus.MULSelB, bus.MulStart, bus.DivStart, bus.RegWriteOut, bus.BRAEn,
            bus.BranchTaken, bus.Stall, bus.AccBusy, bus.OutSel};
  endfunction

  function automatic in_t nop();
    in_t s;
    s    = '{default: '0};
    s.rn = 1'b1;
    return s;
  endfunction

  function automatic in_t rop(input logic [5:0] fn, input logic rwi);
    in_t s;
    s     = nop();
    s.v   = 1'b1;
    s.alu = 1'b1;
    s.fn  = fn;
    s.rwi = rwi;
    return s;
  endfunction

  function automatic in_t mop(input logic [5:0] fn, input logic rwi);
    in_t s;
    s     = rop(fn, rwi);
    s.alu = 1'b0;
    s.mul = 1'b1;
    return s;
  endfunction

  function automatic in_t add_op();
    in_t s;
    s      = rop(6'h20, 1'b1);
    s.alue = 1'b1;
    return s;
  endfunction

  task automatic push(input in_t s, input string nm, input logic [10:0] val, input logic [10:0] mask);
    exp_t e;
    e.nm   = nm;
    e.val  = val;
    e.mask = mask;
    stim_q.push_back(s);
    sb.push_back(e);
  endtask

  task automatic apply(input in_t s);
    nrst           = s.rn;
    bus.Valid      = s.v;
    bus.Flush      = s.fl;
    bus.ALUOp      = s.alu;
    bus.MULOp      = s.mul;
    bus.Jump       = s.j;
    bus.Branch     = s.br;
    bus.BRAtaken   = s.tk;
    bus.RegWriteIn = s.rwi;
    bus.ALUEn      = s.alue;
    bus.MemWrite   = s.mw;
    bus.Func       = s.fn;
  endtask

  task automatic test_reset();
    exp_t e;
    in_t  r;
    r    = nop();
    r.rn = 1'b0;
    push(nop(), "idle", ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    push(rop(FN_DIV, 1'b0), "div_issue", ev(0,0,0,1,0,0,0,0,1,2'b11), M_ALL);
    push(nop(), "div_busy", ev(0,0,0,0,0,0,0,0,1,2'b00), M_ALL);
    push(r, "in_reset0", ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    push(r, "in_reset1", ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    for (int i = 0; i < 32; i++)
      push(nop(), $sformatf("post_reset%0d", i), ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL reset/%s got=%b expected=%b mask=%b", e.nm, obs(), e.val, e.mask);
      end else $display("txn reset/%s outputs=%b", e.nm, obs());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mult();
    exp_t e;
    push(rop(FN_MULT, 1'b0), "mult_issue", ev(0,1,1,0,0,0,0,0,1,2'b10), M_ALL);
    push(add_op(), "add_parallel", ev(0,0,0,0,1,0,0,0,1,2'b00), M_ALL);
    push(nop(), "mult_done", ev(1,0,0,0,0,0,0,0,1,2'b00), M_ALL);
    push(nop(), "after", ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL mult/%s got=%b expected=%b mask=%b", e.nm, obs(), e.val, e.mask);
      end else $display("txn mult/%s outputs=%b", e.nm, obs());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_mflo();
    exp_t e;
    push(rop(FN_DIV, 1'b0), "div_issue", ev(0,0,0,1,0,0,0,0,1,2'b11), M_ALL);
    for (int i = 1; i <= 31; i++)
      push(rop(FN_MFLO, 1'b1), $sformatf("mflo_wait%0d", i),
           ev((i == 31), 0,0,0,0,0,0,1,1,2'b00), M_HOLD);
    push(rop(FN_MFLO, 1'b1), "mflo_issue", ev(0,0,0,0,1,0,0,0,0,2'b10), M_ALL);
    push(nop(), "after", ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL div/%s got=%b expected=%b mask=%b", e.nm, obs(), e.val, e.mask);
      end else $display("txn div/%s outputs=%b", e.nm, obs());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_gpr_mul();
    exp_t e;
    push(mop(FN_MUL, 1'b1), "mul_issue", ev(0,1,1,0,0,0,0,1,0,2'b10), M_ALL);
    push(mop(FN_MUL, 1'b1), "mul_hold", ev(0,0,0,0,0,0,0,1,0,2'b00), M_HOLD);
    push(mop(FN_MUL, 1'b1), "mul_done", ev(0,1,0,0,1,0,0,0,0,2'b10), M_ALL);
    push(nop(), "after", ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL gpr_mul/%s got=%b expected=%b mask=%b", e.nm, obs(), e.val, e.mask);
      end else $display("txn gpr_mul/%s outputs=%b", e.nm, obs());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    exp_t e;
    in_t  s;
    s = nop(); s.v = 1'b1; s.br = 1'b1;
    push(s, "beq_not_taken", ev(0,0,0,0,0,1,0,0,0,2'b01), M_ALL);
    s.tk = 1'b1; s.rwi = 1'b1;
    push(s, "br_taken_link", ev(0,0,0,0,1,1,1,0,0,2'b01), M_ALL);
    s.fl = 1'b1;
    push(s, "br_flushed", ev(0,0,0,0,0,1,0,0,0,2'b00), M_NOOS);
    s = nop(); s.v = 1'b1; s.j = 1'b1; s.rwi = 1'b1;
    push(s, "jal", ev(0,0,0,0,1,1,1,0,0,2'b01), M_ALL);
    push(mop(FN_CLZ, 1'b1), "clz", ev(0,0,0,0,1,0,0,0,0,2'b10), M_ALL);
    push(rop(FN_MTHI, 1'b0), "mthi", ev(1,0,0,0,0,0,0,0,0,2'b10), M_ALL);
    s = nop(); s.v = 1'b1; s.alue = 1'b1; s.mw = 1'b1;
    push(s, "store", ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    s.mw = 1'b0;
    push(s, "alu_imm", ev(0,0,0,0,1,0,0,0,0,2'b00), M_ALL);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL branch/%s got=%b expected=%b mask=%b", e.nm, obs(), e.val, e.mask);
      end else $display("txn branch/%s outputs=%b", e.nm, obs());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    exp_t e;
    in_t  s;
    push(mop(FN_MUL, 1'b1), "mul_issue", ev(0,1,1,0,0,0,0,1,0,2'b10), M_ALL);
    s = mop(FN_MUL, 1'b1); s.fl = 1'b1;
    push(s, "mul_flushed", ev(0,0,0,0,0,0,0,0,0,2'b00), M_HOLD);
    push(nop(), "idle_after_abort", ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    push(add_op(), "add_after_abort", ev(0,0,0,0,1,0,0,0,0,2'b00), M_ALL);
    push(rop(FN_MULT, 1'b0), "mult_issue", ev(0,1,1,0,0,0,0,0,1,2'b10), M_ALL);
    s = add_op(); s.fl = 1'b1;
    push(s, "add_flushed", ev(0,0,0,0,0,0,0,0,1,2'b00), M_NOOS);
    s = nop(); s.fl = 1'b1;
    push(s, "acc_done_flush", ev(1,0,0,0,0,0,0,0,1,2'b00), M_NOOS);
    push(nop(), "after", ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL flush/%s got=%b expected=%b mask=%b", e.nm, obs(), e.val, e.mask);
      end else $display("txn flush/%s outputs=%b", e.nm, obs());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    push(rop(FN_MULT, 1'b0), "mult_issue", ev(0,1,1,0,0,0,0,0,1,2'b10), M_ALL);
    push(mop(FN_MADD, 1'b0), "madd_stall", ev(0,0,0,0,0,0,0,1,1,2'b00), M_HOLD);
    push(mop(FN_MADD, 1'b0), "madd_stall_done", ev(1,0,0,0,0,0,0,1,1,2'b00), M_HOLD);
    push(mop(FN_MADD, 1'b0), "madd_issue", ev(0,1,1,0,0,0,0,0,1,2'b10), M_ALL);
    push(nop(), "madd_busy", ev(0,0,0,0,0,0,0,0,1,2'b00), M_ALL);
    push(nop(), "madd_done", ev(1,0,0,0,0,0,0,0,1,2'b00), M_ALL);
    push(nop(), "after", ev(0,0,0,0,0,0,0,0,0,2'b00), M_ALL);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL b2b/%s got=%b expected=%b mask=%b", e.nm, obs(), e.val, e.mask);
      end else $display("txn b2b/%s outputs=%b", e.nm, obs());
      @(posedge clk); #1;
    end
  endtask

  initial begin
    in_t r;
    r    = nop();
    r.rn = 1'b0;
    apply(r);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mult();
    test_div_mflo();
    test_gpr_mul();
    test_branch();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_control_mc.md
Name: ex_control_mc

Overview:
- Next-generation execute-stage controller that adds multi-cycle MUL/DIV sequencing to single-cycle ALU/branch decode.
- Tracks one in-flight accumulator (HI/LO) operation and interlocks later instructions that use the accumulator.
- Stalls the pipeline for GPR-writing multiplies.
- Sits in EX between ID/EX control fields and the ALU, MUL, DIV, ACC and BRA datapath modules.

Parameters:
- MUL_LAT, 3, MUL datapath latency in cycles (>=1); 1 means fully combinational behaviour.
- DIV_LAT, 32, DIV datapath latency in cycles (>=2).
- CNT_W, $clog2(DIV_LAT+1), width of the latency counter (derived; do not override).

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- Valid  in  1  instruction in EX is valid
- Flush  in  1  kill instruction in EX this cycle
- ALUOp  in  1  SPECIAL-class op
- MULOp  in  1  SPECIAL2-class op
- Jump  in  1  jump instruction
- Branch  in  1  conditional branch
- BRAtaken  in  1  branch condition true
- RegWriteIn  in  1  decoded GPR write enable
- ALUEn  in  1  ALU op writes GPR
- MemWrite  in  1  store instruction
- Func  in  6  function field
- ACCEn  out  1  ACC write strobe
- MULSelB  out  1  MUL operand-B select
- MulStart  out  1  one-cycle MUL launch pulse
- DivStart  out  1  one-cycle DIV launch pulse
- RegWriteOut  out  1  final GPR write enable
- BRAEn  out  1  branch unit enable
- BranchTaken  out  1  redirect fetch
- Stall  out  1  hold IF/ID/EX
- AccBusy  out  1  ACC op in flight
- OutSel  out  2  00 ALU, 01 BRA, 10 MUL/ACC, 11 DIV

Behaviour:
- Clock and reset: single clock clk. Synchronous active-low reset nrst. While nrst=0 at a clk edge: state IDLE, counter 0, all registered outputs 0.
- Combinational outputs default to 0 except RegWriteOut=RegWriteIn and BRAEn=Jump|Branch.
- Issue condition: issue = Valid & !Flush & !Stall. MulStart, DivStart and ACCEn from issue are gated by issue.
- Op classes from Func:
  - ACC-long: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B under ALUOp; MADD 0x00, MADDU 0x01, MSUB 0x04, MSUBU 0x05 under MULOp.
  - GPR-mul: MUL 0x02 under MULOp.
  - ACC-move: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - CLZ 0x20 and CLO 0x21: single-cycle, OutSel=10, no ACC.
- ACC user: any instruction in ACC-long, GPR-mul or ACC-move.
- State machine: states IDLE, ACC_BUSY, GPR_BUSY.
- IDLE:
  - ACC-long issue: MulStart or DivStart=1, MULSelB=1 for multiplies, counter loads LAT-1.
    - If LAT=1 (MUL only): ACCEn=1 the same cycle and state stays IDLE.
    - Otherwise state goes to ACC_BUSY and the instruction retires (no Stall).
  - GPR-mul issue with MUL_LAT>1: MulStart=1, Stall=1, counter loads MUL_LAT-1, state goes to GPR_BUSY.
  - ACC-move: ACCEn=1 (MT*), OutSel=10, single cycle.
- ACC_BUSY:
  - AccBusy=1 and the counter decrements each cycle.
  - Completion cycle is counter==1: ACCEn=1, OutSel is unaffected, next state IDLE.
  - A Valid ACC user in EX gives Stall=1 and RegWriteOut=0 through the completion cycle. It issues the cycle after.
  - Non-ACC instructions (ALU, branch, load/store) issue normally in parallel.
- GPR_BUSY:
  - Stall=1 while counter>1.
  - Completion cycle: Stall=0, OutSel=10, RegWriteOut=RegWriteIn, MULSelB=1, next state IDLE.
- ALU default: for non-special Func, OutSel=00 and RegWriteOut=ALUEn & !MemWrite.
- Jump: OutSel=01, BranchTaken=1, RegWriteOut=RegWriteIn.
- Branch: OutSel=01, BranchTaken=BRAtaken, RegWriteOut=RegWriteIn & BRAtaken.
- Branch gating: all branch outputs are gated by issue.
- Flush:
  - Kills the EX instruction: RegWriteOut=0, no start pulses.
  - Does not abort ACC_BUSY, because that op has already retired.
  - Aborts GPR_BUSY to IDLE with no RegWriteOut.
- Simultaneous Flush and ACC completion: ACCEn is still asserted.
- Reset mid-operation: any state returns to IDLE next edge, with no ACCEn.
- Counter is CNT_W bits and never wraps: it saturates at 0 in IDLE.

Decomposition:
- Package ex_ctrl_pkg holds:
  - Func constants, reusing the alu/mul definition values.
  - OutSel enum: OUT_ALU, OUT_BRA, OUT_MUL, OUT_DIV.
  - State enum: IDLE, ACC_BUSY, GPR_BUSY.
- One sub-module, ex_lat_counter: load, decrement, done==1 flag, parameterised width.

Test Plan:
- Reset: nrst=0 for 2 cycles mid ACC_BUSY -> all outputs 0, AccBusy=0, no ACCEn after release.
- MULT (ALUOp, Func=0x18), MUL_LAT=3:
  - MulStart=1 and Stall=0 at cycle 0.
  - AccBusy=1 for cycles 0-2, ACCEn=1 at cycle 2.
  - Unrelated ADD issues at cycle 1 with RegWriteOut=1.
- DIV (Func=0x1A), DIV_LAT=32, then MFLO (0x12) at cycle 1 -> Stall=1 for cycles 1-31, ACCEn at cycle 31, MFLO issues at cycle 32 with OutSel=10.
- MUL (MULOp, 0x02), MUL_LAT=3 -> Stall=1 for cycles 0-1; cycle 2: Stall=0, OutSel=10, RegWriteOut=1.
- BEQ with BRAtaken=0, then BRAtaken=1 -> BranchTaken=0/1, RegWriteOut=0/RegWriteIn, OutSel=01 in both; with Flush=1, BranchTaken=0.
- Flush during GPR_BUSY at cycle 1 -> next cycle IDLE, Stall=0, no RegWriteOut; Flush during ACC_BUSY -> ACCEn still fires on schedule.
